// File: rtl/demux_1x4_stream_if.sv
// demux_1x4_stream_if: bundle of the producer-side and consumer-side
// handshake signals of the 1-to-4 stream demultiplexer.
//   din/sel/in_valid/in_ready : single producer, word plus destination select
//   a..d / *_valid / *_ready  : four independent consumer channels
//   busy                      : any channel holds data
// master: producer/consumer side; slave: the demultiplexer itself.
interface demux_1x4_stream_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic [1:0]       sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             a_valid;
  logic             b_valid;
  logic             c_valid;
  logic             d_valid;
  logic             a_ready;
  logic             b_ready;
  logic             c_ready;
  logic             d_ready;
  logic             busy;

  modport master (
    output din, sel, in_valid, a_ready, b_ready, c_ready, d_ready,
    input  in_ready, a, b, c, d, a_valid, b_valid, c_valid, d_valid, busy
  );

  modport slave (
    input  din, sel, in_valid, a_ready, b_ready, c_ready, d_ready,
    output in_ready, a, b, c, d, a_valid, b_valid, c_valid, d_valid, busy
  );
endinterface

// File: rtl/demux_1x4_stream.sv
// demux_1x4_stream: streaming 1-to-4 demultiplexer. Each accepted input word
// is routed by sel (00=a, 01=b, 10=c, 11=d) into a per-channel FIFO of DEPTH
// entries; each channel drains independently through its own valid/ready.
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset, empties all FIFOs and clears storage
//   bus  : demux_1x4_stream_if slave modport (producer + four consumers)
// in_ready depends only on sel and registered counts; outputs are driven
// from registered state only, so a pushed word is visible one edge later.
module demux_1x4_stream #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input logic                clk,
  input logic                rst,
  demux_1x4_stream_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem    [4][DEPTH];
  logic [AW-1:0]    rd_ptr [4];
  logic [AW-1:0]    wr_ptr [4];
  logic [AW:0]      count  [4];

  logic [3:0] valid;
  logic [3:0] ready;
  logic [3:0] full;
  logic [3:0] push_en;
  logic [3:0] pop_en;
  logic       push;

  always_comb begin
    valid   = '0;
    full    = '0;
    push_en = '0;
    ready   = {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready};
    for (int unsigned i = 0; i < 4; i++) begin
      valid[i] = (count[i] != '0);
      full[i]  = (count[i] == FULL_CNT);
    end
    // A same-cycle pop never frees space for the push: full stays not-ready.
    push          = bus.in_valid && !full[bus.sel];
    push_en[bus.sel] = push;
    pop_en        = valid & ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
          mem[i][j] <= '0;
        end
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (push_en[i]) begin
          mem[i][wr_ptr[i]] <= bus.din;
          wr_ptr[i]         <= wr_ptr[i] + AW'(1);
        end
        if (pop_en[i]) begin
          rd_ptr[i] <= rd_ptr[i] + AW'(1);
        end
        case ({push_en[i], pop_en[i]})
          2'b10:   count[i] <= count[i] + (AW+1)'(1);
          2'b01:   count[i] <= count[i] - (AW+1)'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  assign bus.in_ready = !full[bus.sel];
  assign bus.a        = mem[0][rd_ptr[0]];
  assign bus.b        = mem[1][rd_ptr[1]];
  assign bus.c        = mem[2][rd_ptr[2]];
  assign bus.d        = mem[3][rd_ptr[3]];
  assign bus.a_valid  = valid[0];
  assign bus.b_valid  = valid[1];
  assign bus.c_valid  = valid[2];
  assign bus.d_valid  = valid[3];
  assign bus.busy     = |valid;
endmodule

// File: tb/tb_demux_1x4_stream.sv
module tb_demux_1x4_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  demux_1x4_stream_if #(.WIDTH(4)) bus ();

  demux_1x4_stream #(.WIDTH(4), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic       iv;
    logic [3:0] din;
    logic [1:0] sel;
    logic [3:0] rdy;   // {d,c,b,a}
    logic       e_ir;
    logic [3:0] e_val; // {d,c,b,a}
    logic [3:0] e_a;
    logic [3:0] e_b;
    logic [3:0] e_c;
    logic [3:0] e_d;
    logic       e_busy;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic [3:0] r);
    {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready} = r;
  endtask

  function automatic logic [3:0] valids();
    return {bus.d_valid, bus.c_valid, bus.b_valid, bus.a_valid};
  endfunction

  // Push one word, waiting (bounded) for in_ready.
  task automatic push_word(input logic [1:0] s, input logic [3:0] w);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.sel      = s;
    bus.din      = w;
    #1;
    while (!bus.in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!bus.in_ready) check("push_timeout", int'(s), 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  logic [3:0] q[$];
  logic [3:0] hd;

  initial begin
    bus.in_valid = 1'b0;
    bus.din      = '0;
    bus.sel      = '0;
    set_ready(4'b0000);

    //            iv    din   sel    rdy       ir    val      a     b     c     d     busy
    vecs[0]  = '{1'b0,4'h0,2'd0,4'b0000, 1'b1,4'b0000,4'h0,4'h0,4'h0,4'h0,1'b0};
    vecs[1]  = '{1'b1,4'h3,2'd0,4'b0000, 1'b1,4'b0000,4'h0,4'h0,4'h0,4'h0,1'b0};
    vecs[2]  = '{1'b1,4'h5,2'd1,4'b0000, 1'b1,4'b0001,4'h3,4'h0,4'h0,4'h0,1'b1};
    vecs[3]  = '{1'b1,4'hA,2'd2,4'b0000, 1'b1,4'b0011,4'h3,4'h5,4'h0,4'h0,1'b1};
    vecs[4]  = '{1'b1,4'hF,2'd3,4'b0000, 1'b1,4'b0111,4'h3,4'h5,4'hA,4'h0,1'b1};
    vecs[5]  = '{1'b0,4'h0,2'd0,4'b0000, 1'b1,4'b1111,4'h3,4'h5,4'hA,4'hF,1'b1};
    vecs[6]  = '{1'b0,4'h0,2'd2,4'b0100, 1'b1,4'b1111,4'h3,4'h5,4'hA,4'hF,1'b1};
    vecs[7]  = '{1'b1,4'h1,2'd2,4'b0000, 1'b1,4'b1011,4'h3,4'h5,4'h0,4'hF,1'b1};
    vecs[8]  = '{1'b1,4'h2,2'd2,4'b0000, 1'b1,4'b1111,4'h3,4'h5,4'h1,4'hF,1'b1};
    vecs[9]  = '{1'b1,4'h7,2'd2,4'b0000, 1'b0,4'b1111,4'h3,4'h5,4'h1,4'hF,1'b1};
    vecs[10] = '{1'b0,4'h7,2'd0,4'b0000, 1'b1,4'b1111,4'h3,4'h5,4'h1,4'hF,1'b1};
    vecs[11] = '{1'b1,4'h7,2'd2,4'b0100, 1'b0,4'b1111,4'h3,4'h5,4'h1,4'hF,1'b1};
    vecs[12] = '{1'b1,4'h7,2'd2,4'b0000, 1'b1,4'b1111,4'h3,4'h5,4'h2,4'hF,1'b1};
    vecs[13] = '{1'b0,4'h7,2'd2,4'b0100, 1'b0,4'b1111,4'h3,4'h5,4'h2,4'hF,1'b1};
    vecs[14] = '{1'b0,4'h7,2'd2,4'b0100, 1'b1,4'b1111,4'h3,4'h5,4'h7,4'hF,1'b1};
    vecs[15] = '{1'b0,4'h0,2'd2,4'b0100, 1'b1,4'b1011,4'h3,4'h5,4'h2,4'hF,1'b1};
    vecs[16] = '{1'b0,4'h0,2'd2,4'b0000, 1'b1,4'b1011,4'h3,4'h5,4'h2,4'hF,1'b1};

    // Reset for two cycles.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Table: outputs are checked with the vector's inputs applied, before its edge.
    for (int i = 0; i < 17; i++) begin
      bus.in_valid = vecs[i].iv;
      bus.din      = vecs[i].din;
      bus.sel      = vecs[i].sel;
      set_ready(vecs[i].rdy);
      #1;
      check("in_ready", i, 32'(bus.in_ready), 32'(vecs[i].e_ir));
      check("valid",    i, 32'(valids()),     32'(vecs[i].e_val));
      check("a",        i, 32'(bus.a),        32'(vecs[i].e_a));
      check("b",        i, 32'(bus.b),        32'(vecs[i].e_b));
      check("c",        i, 32'(bus.c),        32'(vecs[i].e_c));
      check("d",        i, 32'(bus.d),        32'(vecs[i].e_d));
      check("busy",     i, 32'(bus.busy),     32'(vecs[i].e_busy));
      tick();
    end
    bus.in_valid = 1'b0;
    set_ready(4'b0000);

    // Channel d holds F; push 0..7 with d_ready held, across pointer wrap.
    q.delete();
    q.push_back(4'hF);
    set_ready(4'b1000);
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 1'b1;
      bus.sel      = 2'd3;
      bus.din      = 4'(k);
      #1;
      check("wrap_in_ready", k, 32'(bus.in_ready), 32'd1);
      check("wrap_d_valid",  k, 32'(bus.d_valid),  32'd1);
      check("wrap_d",        k, 32'(bus.d),        32'(q[0]));
      hd = q.pop_front();
      q.push_back(4'(k));
      tick();
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      #1;
      check("wrap_drain_valid", k, 32'(bus.d_valid), 32'd1);
      check("wrap_drain_d",     k, 32'(bus.d),       32'(q[0]));
      hd = q.pop_front();
      tick();
    end
    check("wrap_empty_q", 0, 32'(q.size()), 32'd0);
    check("wrap_d_done", 0, 32'(bus.d_valid), 32'd0);
    set_ready(4'b0000);

    // Independence: fill b, then stream 10 words through a while b is stalled.
    push_word(2'd1, 4'h9);
    bus.sel = 2'd1;
    #1;
    check("b_full_ready", 0, 32'(bus.in_ready), 32'd0);
    q.delete();
    q.push_back(4'h3);
    set_ready(4'b0001);
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = 1'b1;
      bus.sel      = 2'd0;
      bus.din      = 4'(k) ^ 4'hC;
      #1;
      check("ind_in_ready", k, 32'(bus.in_ready), 32'd1);
      check("ind_a",        k, 32'(bus.a),        32'(q[0]));
      check("ind_b",        k, 32'(bus.b),        32'h5);
      hd = q.pop_front();
      q.push_back(4'(k) ^ 4'hC);
      tick();
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      #1;
      check("ind_drain_a", k, 32'(bus.a), 32'(q[0]));
      hd = q.pop_front();
      tick();
    end
    check("ind_a_done", 0, 32'(bus.a_valid), 32'd0);
    set_ready(4'b0010);
    #1;
    check("ind_b_head", 0, 32'(bus.b), 32'h5);
    tick();
    set_ready(4'b0000);
    #1;
    check("ind_b_next", 0, 32'(bus.b), 32'h9);
    check("ind_b_valid", 0, 32'(bus.b_valid), 32'd1);

    // Fill every channel, then reset while pushing and popping.
    push_word(2'd0, 4'h1);
    push_word(2'd0, 4'h2);
    push_word(2'd1, 4'h3);
    push_word(2'd2, 4'h4);
    push_word(2'd2, 4'h5);
    push_word(2'd3, 4'h6);
    push_word(2'd3, 4'h8);
    for (int s = 0; s < 4; s++) begin
      bus.sel = 2'(s);
      #1;
      check("full_in_ready", s, 32'(bus.in_ready), 32'd0);
    end
    check("full_valid", 0, 32'(valids()), 32'hF);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.din      = 4'hE;
    bus.sel      = 2'd0;
    set_ready(4'b1111);
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    set_ready(4'b0000);
    #1;
    check("rst_valid",    0, 32'(valids()),     32'd0);
    check("rst_busy",     0, 32'(bus.busy),     32'd0);
    check("rst_in_ready", 0, 32'(bus.in_ready), 32'd1);
    check("rst_data", 0, 32'({bus.a, bus.b, bus.c, bus.d}), 32'd0);
    tick();
    check("rst_no_store", 0, 32'(valids()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/demux_1x4_stream.md
Name: demux_1x4_stream

Overview:
- Streaming 1-to-4 demultiplexer: the inverse of the team's 4:1 mux.
- Each accepted 4-bit input word is routed by a 2-bit select to one of four output channels a/b/c/d.
- Each output channel has its own small FIFO and a valid/ready handshake, so a stalled channel blocks only traffic addressed to it.
- Sits between a single producer and four independent consumers.

Parameters:
- WIDTH, 4, data width of the input word and of each output channel.
- DEPTH, 2, entries per channel FIFO; power of two, at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  input data word.
- sel  input  2  destination select: 00=a, 01=b, 10=c, 11=d.
- in_valid  input  1  producer has a word on din/sel.
- in_ready  output  1  block can accept the word to the currently selected channel.
- a, b, c, d  output  WIDTH each  head-of-FIFO data for each channel.
- a_valid, b_valid, c_valid, d_valid  output  1 each  channel FIFO non-empty.
- a_ready, b_ready, c_ready, d_ready  input  1 each  consumer accepts the head word.
- busy  output  1  any channel FIFO non-empty.

Behaviour:
- Reset
  - On a clk edge with rst=1, all four FIFOs are emptied: pointers and counts cleared, storage cleared to 0.
  - After reset: all *_valid=0, all data outputs=0, busy=0, in_ready=1.
  - Reset wins over any simultaneous push or pop. Words in flight are discarded.
- Input handshake
  - in_ready = !full[sel], combinational from sel and the registered FIFO counts. No dependency on in_valid.
  - A push occurs on an edge where in_valid && in_ready. din is written to FIFO[sel].
  - in_ready does not consider a same-cycle pop on the target channel; a full channel stays not-ready for that cycle.
  - A word presented while its channel is full is held by the producer. The producer must keep din/sel stable until accepted. The block never drops data.
- Output handshake (per channel X)
  - X_valid = (count_X != 0). X = storage at read pointer_X, driven combinationally from registered state.
  - A pop occurs on an edge where X_valid && X_ready.
  - X_ready while X_valid=0 has no effect.
- Latency
  - A word pushed on edge N appears on its channel (X_valid=1) after edge N. This is one cycle of latency; there is no combinational pass-through from din.
- Ordering
  - FIFO order per channel.
  - No ordering guarantee across channels; each channel drains independently.
- Simultaneous events
  - Push and pop on the same channel in the same edge (channel not full): count unchanged, both pointers advance.
  - Pops on several channels in one edge are independent.
  - Only one push per edge is possible.
- Pointers and count
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits, range 0..DEPTH.
  - full = (count == DEPTH); empty = (count == 0).
- Status: busy = OR of the four *_valid, combinational.
- Select change: changing sel while in_valid=0 is legal at any time. in_ready follows the new sel in the same cycle.

Test Plan:
- Reset/idle: assert rst for 2 cycles, release -> in_ready=1; all *_valid=0; a=b=c=d=0; busy=0.
- Basic routing:
  - Stimulus: push 4'h3 sel=00, 4'h5 sel=01, 4'hA sel=10, 4'hF sel=11 on consecutive cycles, all *_ready=0.
  - Response: a=3, b=5, c=A, d=F; each *_valid rises exactly one cycle after its push; busy=1.
- Full/backpressure:
  - Stimulus: with c_ready=0, push 4'h1, 4'h2 to sel=10, then present 4'h7 sel=10.
  - Response: in_ready=0 and 4'h7 is not accepted. Switching sel to 00 gives in_ready=1 the same cycle.
  - Then raise c_ready for one cycle -> c=2 next. The held 4'h7 is accepted on the following edge and appears after 4'h2.
- Simultaneous push/pop with wrap:
  - Stimulus: channel d holds 1 entry, d_ready=1 held, push 8 words 0..7 to sel=11 back-to-back.
  - Response: d_valid stays 1; outputs appear in order with no loss across pointer wrap.
- Reset mid-operation:
  - Stimulus: all channels full, pulse rst for 1 cycle while in_valid=1 and all *_ready=1.
  - Response: after the edge all *_valid=0, data outputs=0, in_ready=1; the pushed word is not stored.
- Independence: stall b (b_ready=0, full) while streaming 10 words to a with a_ready=1 -> all 10 delivered to a in order; b contents unchanged.
